// File: rtl/axi_lite_rd_arbiter_if.sv
// Purpose : bundles the two-requester AXI-Lite read channels and the single
//           slave-side read channel that the read arbiter sits between.
// Ports   : s_axi_* = requester side (index 0/1), m_axi_* = register-file side.
// Modports: slave  = the arbiter's view (it is the slave to both requesters
//                    and drives the address/ready towards the register file).
//           master = the environment's view (requesters plus register file).
interface axi_lite_rd_arbiter_if;

    // requester side, one lane per requester
    logic [1:0][31:0] s_axi_araddr;
    logic [1:0][2:0]  s_axi_arprot;
    logic [1:0]       s_axi_arvalid;
    logic [1:0]       s_axi_arready;
    logic [31:0]      s_axi_rdata;
    logic [1:0]       s_axi_rresp;
    logic [1:0]       s_axi_rvalid;
    logic [1:0]       s_axi_rready;

    // register-file side
    logic [31:0]      m_axi_araddr;
    logic [2:0]       m_axi_arprot;
    logic             m_axi_arvalid;
    logic             m_axi_arready;
    logic [31:0]      m_axi_rdata;
    logic [1:0]       m_axi_rresp;
    logic             m_axi_rvalid;
    logic             m_axi_rready;

    modport slave (
        input  s_axi_araddr, s_axi_arprot, s_axi_arvalid, s_axi_rready,
        output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        output m_axi_araddr, m_axi_arprot, m_axi_arvalid, m_axi_rready,
        input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
    );

    modport master (
        output s_axi_araddr, s_axi_arprot, s_axi_arvalid, s_axi_rready,
        input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        input  m_axi_araddr, m_axi_arprot, m_axi_arvalid, m_axi_rready,
        output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
    );

endinterface

// File: rtl/axi_lite_rd_arbiter.sv
// Purpose : round-robin arbiter merging two AXI-Lite read requesters onto one
//           register-file read port, one read outstanding at a time.
// Latency : AR accept -> rvalid in 3 cycles with a zero-wait slave; next AR
//           accept 4 cycles after the previous one.
// Backpr. : requesters stall (arready=0) outside IDLE; slave arready/rvalid and
//           requester rready stretch ADDR/DATA/RESP indefinitely.
// Ports   : aclk, areset (sync, active high); bus (slave modport) carries all
//           AXI-Lite read signals; arb_busy = not IDLE; arb_grant = current or
//           last granted requester.
module axi_lite_rd_arbiter (
    input  logic                        aclk,
    input  logic                        areset,
    axi_lite_rd_arbiter_if.slave        bus,
    output logic                        arb_busy,
    output logic                        arb_grant
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_last_grant;   // requester whose read completed most recently
    logic        r_grant;        // requester owning the current/last transaction
    logic        r_busy;
    logic        r_m_arvalid;
    logic [31:0] r_m_araddr;
    logic [2:0]  r_m_arprot;
    logic [31:0] r_s_rdata;
    logic [1:0]  r_s_rresp;
    logic [1:0]  r_s_rvalid;

    logic        w_win;          // winner index among current requesters
    logic [1:0]  w_arready;
    logic        w_ar_hs;
    logic        w_r_hs;

    // Contention goes to whoever did not complete last; a lone requester wins
    // outright regardless of history.
    always_comb begin
        w_win = 1'b0;
        if (bus.s_axi_arvalid == 2'b11) begin
            w_win = ~r_last_grant;
        end else if (bus.s_axi_arvalid[1]) begin
            w_win = 1'b1;
        end
    end

    // Ready is offered only to the winner and only while IDLE, so the loser's
    // request simply stays pending on its own valid line.
    always_comb begin
        w_arready = 2'b00;
        if ((r_state == ST_IDLE) && (bus.s_axi_arvalid != 2'b00)) begin
            w_arready = w_win ? 2'b10 : 2'b01;
        end
    end

    assign w_ar_hs = (w_arready & bus.s_axi_arvalid) != 2'b00;
    // Only the granted requester's rready can close the response.
    assign w_r_hs  = (r_state == ST_RESP) && bus.s_axi_rready[r_grant];

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_busy       <= 1'b0;
            r_m_arvalid  <= 1'b0;
            r_m_araddr   <= 32'd0;
            r_m_arprot   <= 3'd0;
            r_s_rdata    <= 32'd0;
            r_s_rresp    <= 2'b00;
            r_s_rvalid   <= 2'b00;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_ar_hs) begin
                        r_m_araddr  <= bus.s_axi_araddr[w_win];
                        r_m_arprot  <= bus.s_axi_arprot[w_win];
                        r_grant     <= w_win;
                        r_m_arvalid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (bus.m_axi_arready) begin
                        r_m_arvalid <= 1'b0;
                        r_state     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // Response code is forwarded untouched, errors included.
                    if (bus.m_axi_rvalid) begin
                        r_s_rdata  <= bus.m_axi_rdata;
                        r_s_rresp  <= bus.m_axi_rresp;
                        r_s_rvalid <= r_grant ? 2'b10 : 2'b01;
                        r_state    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (w_r_hs) begin
                        r_s_rvalid   <= 2'b00;
                        r_last_grant <= r_grant;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.s_axi_arready = w_arready;
    assign bus.s_axi_rdata   = r_s_rdata;
    assign bus.s_axi_rresp   = r_s_rresp;
    assign bus.s_axi_rvalid  = r_s_rvalid;
    assign bus.m_axi_araddr  = r_m_araddr;
    assign bus.m_axi_arprot  = r_m_arprot;
    assign bus.m_axi_arvalid = r_m_arvalid;
    assign bus.m_axi_rready  = (r_state == ST_DATA);
    assign arb_busy          = r_busy;
    assign arb_grant         = r_grant;

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// Purpose : self-checking bench for axi_lite_rd_arbiter: requester/slave agents,
//           a transaction-level reference model compared every cycle, and
//           directed scenarios with literal expectations.
module tb_axi_lite_rd_arbiter;

    logic aclk = 1'b0;
    logic areset;
    logic arb_busy;
    logic arb_grant;

    axi_lite_rd_arbiter_if bus ();

    axi_lite_rd_arbiter dut (
        .aclk      (aclk),
        .areset    (areset),
        .bus       (bus),
        .arb_busy  (arb_busy),
        .arb_grant (arb_grant)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- stimulus knobs (written by the main test) -------------
    logic [31:0] req_addr [2];
    logic [2:0]  req_prot [2];
    int          req_cnt  [2];   // reads still to issue per requester
    int          rdelay   [2];   // cycles a requester withholds rready once rvalid shows
    int          ar_stall;       // cycles the slave withholds arready
    logic        spur;           // slave drives junk rvalid while AR is pending
    logic [1:0]  slave_resp;
    logic        pending;
    logic [31:0] pend_data;

    // ---------------- observation logs --------------------------------------
    int          hs_log[$];
    logic [31:0] addr_log[$];
    int          marv_cyc;
    int          ardy_busy;
    int          rv1_cyc;
    logic [31:0] last_rdata;
    logic [1:0]  last_rresp;

    // ---------------- requester + slave agents ------------------------------
    initial begin : agent
        logic [1:0] ar_hs;
        logic       m_ar_hs;
        logic       m_r_hs;
        logic       stall_dec;
        logic [1:0] rv;
        forever begin
            @(negedge aclk);
            ar_hs     = bus.s_axi_arvalid & bus.s_axi_arready;
            m_ar_hs   = bus.m_axi_arvalid && bus.m_axi_arready;
            m_r_hs    = bus.m_axi_rvalid && bus.m_axi_rready;
            stall_dec = bus.m_axi_arvalid && !bus.m_axi_arready;
            rv        = bus.s_axi_rvalid;
            if (ar_hs[0]) hs_log.push_back(0);
            if (ar_hs[1]) hs_log.push_back(1);
            if (m_ar_hs) addr_log.push_back(bus.m_axi_araddr);
            if (bus.m_axi_arvalid) marv_cyc++;
            if (arb_busy && bus.s_axi_arready != 2'b00) ardy_busy++;
            if (rv == 2'b10) rv1_cyc++;
            if (rv != 2'b00) begin
                last_rdata = bus.s_axi_rdata;
                last_rresp = bus.s_axi_rresp;
            end
            @(posedge aclk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (ar_hs[i] && req_cnt[i] > 0) req_cnt[i]--;
                if (rv[i] && rdelay[i] > 0) rdelay[i]--;
            end
            if (stall_dec && ar_stall > 0) ar_stall--;
            if (m_r_hs) pending = 1'b0;
            if (m_ar_hs) begin
                pending   = 1'b1;
                pend_data = 32'hDEADBEEB ^ bus.m_axi_araddr;
            end
            for (int i = 0; i < 2; i++) begin
                bus.s_axi_arvalid[i] = (req_cnt[i] > 0);
                bus.s_axi_araddr[i]  = req_addr[i];
                bus.s_axi_arprot[i]  = req_prot[i];
                bus.s_axi_rready[i]  = (rdelay[i] == 0);
            end
            bus.m_axi_arready = (ar_stall == 0);
            bus.m_axi_rvalid  = pending | (spur & bus.m_axi_arvalid);
            bus.m_axi_rdata   = pending ? pend_data : 32'hBAD0BAD0;
            bus.m_axi_rresp   = slave_resp;
        end
    end

    // ---------------- reference model ---------------------------------------
    // One record describes the single read in flight: who owns it, what it
    // asked for, and how far it has got (0 = address offered to the slave,
    // 1 = waiting for slave data, 2 = data offered to the requester).
    bit          m_valid = 0;
    bit          m_busy;
    int          m_phase;
    int          m_cur;
    int          m_last;
    int          m_grant;
    logic [31:0] m_addr;
    logic [2:0]  m_prot;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;

    function automatic int pick(input logic [1:0] av, input int last);
        if (av == 2'b11) return 1 - last;
        return (av == 2'b10) ? 1 : 0;
    endfunction

    initial begin : model
        int w;
        forever begin
            @(posedge aclk);
            if (areset) begin
                m_valid = 1; m_busy = 0; m_phase = 0; m_cur = 0;
                m_last = 1; m_grant = 0; m_addr = 0; m_prot = 0;
                m_rdata = 0; m_rresp = 0;
            end else if (m_valid) begin
                if (!m_busy) begin
                    if (bus.s_axi_arvalid != 2'b00) begin
                        w       = pick(bus.s_axi_arvalid, m_last);
                        m_busy  = 1;
                        m_phase = 0;
                        m_cur   = w;
                        m_grant = w;
                        m_addr  = bus.s_axi_araddr[w];
                        m_prot  = bus.s_axi_arprot[w];
                    end
                end else if (m_phase == 0) begin
                    if (bus.m_axi_arready) m_phase = 1;
                end else if (m_phase == 1) begin
                    if (bus.m_axi_rvalid) begin
                        m_rdata = bus.m_axi_rdata;
                        m_rresp = bus.m_axi_rresp;
                        m_phase = 2;
                    end
                end else begin
                    if (bus.s_axi_rready[m_cur]) begin
                        m_busy = 0;
                        m_last = m_cur;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare -------------------------------------
    initial begin : compare
        logic [1:0] exp_ardy;
        logic [1:0] exp_srv;
        forever begin
            @(negedge aclk);
            if (m_valid) begin
                exp_ardy = 2'b00;
                if (!m_busy && bus.s_axi_arvalid != 2'b00)
                    exp_ardy = (pick(bus.s_axi_arvalid, m_last) == 1) ? 2'b10 : 2'b01;
                exp_srv = (m_busy && m_phase == 2) ? ((m_cur == 1) ? 2'b10 : 2'b01) : 2'b00;
                chk("s_arready", {30'd0, bus.s_axi_arready}, {30'd0, exp_ardy});
                chk("m_arvalid", {31'd0, bus.m_axi_arvalid}, {31'd0, m_busy && m_phase == 0});
                chk("m_araddr", bus.m_axi_araddr, m_addr);
                chk("m_arprot", {29'd0, bus.m_axi_arprot}, {29'd0, m_prot});
                chk("m_rready", {31'd0, bus.m_axi_rready}, {31'd0, m_busy && m_phase == 1});
                chk("s_rvalid", {30'd0, bus.s_axi_rvalid}, {30'd0, exp_srv});
                chk("s_rdata", bus.s_axi_rdata, m_rdata);
                chk("s_rresp", {30'd0, bus.s_axi_rresp}, {30'd0, m_rresp});
                chk("arb_busy", {31'd0, arb_busy}, {31'd0, m_busy});
                chk("arb_grant", {31'd0, arb_grant}, m_grant[31:0]);
            end
        end
    end

    // ---------------- directed scenarios ------------------------------------
    task automatic tick();
        @(negedge aclk);
        #2;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_cnt[i] = 0; rdelay[i] = 0; req_addr[i] = 0; req_prot[i] = 0;
        end
        ar_stall = 0; spur = 0; slave_resp = 2'b00; pending = 0; pend_data = 0;
        tick();
        tick();
        areset = 1'b0;
        hs_log.delete(); addr_log.delete();
        marv_cyc = 0; ardy_busy = 0; rv1_cyc = 0; last_rdata = 0; last_rresp = 0;
    endtask

    task automatic wait_idle(input string nm);
        for (int k = 0; k < 300 && (req_cnt[0] != 0 || req_cnt[1] != 0 || arb_busy); k++) tick();
        chk(nm, {31'd0, arb_busy}, 32'd0);
    endtask

    initial begin : main
        int exp_g [4];
        logic [31:0] exp_a [4];
        areset = 1'b1;
        bus.s_axi_arvalid = 2'b00; bus.s_axi_araddr = '0; bus.s_axi_arprot = '0;
        bus.s_axi_rready = 2'b11; bus.m_axi_arready = 1'b1; bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rdata = '0; bus.m_axi_rresp = 2'b00;

        // -- reset values and zero-wait latency
        do_reset();
        chk("rst_busy", {31'd0, arb_busy}, 32'd0);
        chk("rst_grant", {31'd0, arb_grant}, 32'd0);
        chk("rst_m_arvalid", {31'd0, bus.m_axi_arvalid}, 32'd0);
        chk("rst_s_rvalid", {30'd0, bus.s_axi_rvalid}, 32'd0);
        chk("rst_rdata", bus.s_axi_rdata, 32'd0);
        chk("rst_rresp", {30'd0, bus.s_axi_rresp}, 32'd0);
        chk("rst_araddr", bus.m_axi_araddr, 32'd0);
        chk("rst_arprot", {29'd0, bus.m_axi_arprot}, 32'd0);
        req_addr[0] = 32'h4; req_prot[0] = 3'b010; req_cnt[0] = 2;
        for (int k = 0; k < 20 && !(bus.s_axi_arvalid[0] && bus.s_axi_arready[0]); k++) tick();
        chk("lat_first_accept", {30'd0, bus.s_axi_arready & bus.s_axi_arvalid}, 32'd1);
        repeat (3) tick();
        chk("lat3_rvalid", {30'd0, bus.s_axi_rvalid}, 32'd1);
        chk("lat3_rdata", bus.s_axi_rdata, 32'hDEADBEEF);
        chk("lat3_rresp", {30'd0, bus.s_axi_rresp}, 32'd0);
        tick();
        chk("lat4_next_accept", {30'd0, bus.s_axi_arready & bus.s_axi_arvalid}, 32'd1);
        wait_idle("lat_idle_timeout");

        // -- round robin under continuous dual request
        do_reset();
        req_addr[0] = 32'h0; req_addr[1] = 32'h8; req_cnt[0] = 2; req_cnt[1] = 2;
        wait_idle("rr_idle_timeout");
        exp_g = '{0, 1, 0, 1};
        exp_a = '{32'h0, 32'h8, 32'h0, 32'h8};
        chk("rr_count", hs_log.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("rr_grant", (i < hs_log.size()) ? hs_log[i] : -1, exp_g[i]);
            chk("rr_addr", (i < addr_log.size()) ? addr_log[i] : 32'hFFFFFFFF, exp_a[i]);
        end

        // -- slave AR stall, second requester waits, junk rvalid ignored
        do_reset();
        ar_stall = 5; spur = 1'b1;
        req_addr[0] = 32'h10; req_addr[1] = 32'h14; req_prot[1] = 3'b111;
        req_cnt[0] = 1; req_cnt[1] = 1;
        wait_idle("stall_idle_timeout");
        chk("stall_marv_cycles", marv_cyc, 32'd7);
        chk("stall_ardy_busy", ardy_busy, 32'd0);
        chk("stall_addr0", (addr_log.size() > 0) ? addr_log[0] : 32'hFFFFFFFF, 32'h10);
        chk("stall_addr1", (addr_log.size() > 1) ? addr_log[1] : 32'hFFFFFFFF, 32'h14);
        chk("stall_rdata", last_rdata, 32'hDEADBEFF);

        // -- SLVERR with requester 1 withholding rready
        do_reset();
        slave_resp = 2'b10; rdelay[1] = 3;
        req_addr[1] = 32'h20; req_prot[1] = 3'b101; req_cnt[1] = 1;
        wait_idle("slverr_idle_timeout");
        chk("slverr_rv_cycles", rv1_cyc, 32'd4);
        chk("slverr_rresp", {30'd0, last_rresp}, 32'd2);
        chk("slverr_rdata", last_rdata, 32'hDEADBECB);

        // -- reset while in DATA drops the read and restores round-robin history
        do_reset();
        req_addr[0] = 32'h4; req_cnt[0] = 2;
        for (int k = 0; k < 40 && !(req_cnt[0] == 0 && bus.m_axi_rready); k++) tick();
        chk("midrst_reach_data", {31'd0, bus.m_axi_rready}, 32'd1);
        areset = 1'b1;
        tick();
        chk("midrst_busy", {31'd0, arb_busy}, 32'd0);
        chk("midrst_m_rready", {31'd0, bus.m_axi_rready}, 32'd0);
        chk("midrst_s_rvalid", {30'd0, bus.s_axi_rvalid}, 32'd0);
        areset = 1'b0;
        req_addr[1] = 32'h8; req_cnt[0] = 1; req_cnt[1] = 1;
        for (int k = 0; k < 20 && bus.s_axi_arready == 2'b00; k++) tick();
        chk("midrst_grant_first", {30'd0, bus.s_axi_arready}, 32'd1);
        wait_idle("midrst_idle_timeout");

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
